// File: rtl/block_data_memory_pkg.sv
// Shared types and default dimensions for the block data memory responder.
package data_mem_pkg;

  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LATENCY = 5;
  localparam int CNT_W       = 4;   // holds LATENCY-2 for LATENCY up to 15

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/block_data_memory_if.sv
// Cache-controller to main-memory block interface; with DATA_MEM_STATS_EN it
// also carries the completed read/write counters.
interface block_data_memory_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;
`ifdef DATA_MEM_STATS_EN
  logic [15:0]       read_count;
  logic [15:0]       write_count;

  modport master (output read, write, address, writedata,
                  input  readdata, busywait, read_count, write_count);
  modport slave  (input  read, write, address, writedata,
                  output readdata, busywait, read_count, write_count);
`else
  modport master (output read, write, address, writedata,
                  input  readdata, busywait);
  modport slave  (input  read, write, address, writedata,
                  output readdata, busywait);
`endif

endinterface

// File: rtl/block_data_memory_latency_counter.sv
// Loadable down-counter that times one memory access; zero flags completion.
module mem_latency_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/block_data_memory.sv
// Block-granular main memory with fixed LATENCY-cycle busywait per access.
// Optional DATA_MEM_STATS_EN adds saturating read/write completion counters.
module block_data_memory
  import data_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic               clock,
  input  logic               reset,
  block_data_memory_if.slave bus
);

  localparam int               DEPTH    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 2);

  state_e            state, next_state;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] readdata_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              req, accept, complete, busy;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt;

  assign req          = bus.read | bus.write;
  assign bus.busywait = busy;
  assign bus.readdata = readdata_q;

  mem_latency_counter #(.WIDTH(CNT_W)) u_latency (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (LOAD_VAL),
    .dec        (state == BUSY),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = req;  // combinational so the requester sees it in its own cycle
        if (req) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_zero) begin
          complete   = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_q    <= bus.read ? OP_READ : OP_WRITE;  // read wins when both are set
        addr_q  <= bus.address;
        wdata_q <= bus.writedata;
      end
      if (complete && op_q == OP_READ) begin
        readdata_q <= mem[addr_q];
      end
    end
  end

  // NOTE: the array is built from resettable flops because reset must clear
  // every word; a RAM macro without a clear port could not honour that.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (complete && op_q == OP_WRITE) begin
      mem[addr_q] <= wdata_q;
    end
  end

`ifdef DATA_MEM_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.read_count  <= '0;
      bus.write_count <= '0;
    end else if (complete) begin
      if (op_q == OP_READ && bus.read_count != 16'hFFFF) begin
        bus.read_count <= bus.read_count + 16'd1;
      end
      if (op_q == OP_WRITE && bus.write_count != 16'hFFFF) begin
        bus.write_count <= bus.write_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: expected readdata queued at issue,
// compared when the access completes; busywait length checked per access.
module tb_block_data_memory;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int LATENCY = 5;
  localparam int BOUND   = 40;

  logic clock;
  logic reset;

  block_data_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  block_data_memory #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int                n_checks = 0;
  int                n_errors = 0;
  int                n_reads  = 0;
  int                n_writes = 0;
  logic [DATA_W-1:0] model [2**ADDR_W];
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] last_read;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b0;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    #1;
    check("rst_busywait", {31'd0, bus.busywait}, 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    for (int i = 0; i < 2**ADDR_W; i++) model[i] = '0;
    sb.delete();
    last_read = '0;
    n_reads   = 0;
    n_writes  = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic start(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    @(negedge clock);
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = d;
    if (rd) begin
      sb.push_back(model[a]);
      n_reads++;
    end else if (wr) begin
      model[a] = d;
      sb.push_back(last_read);
      n_writes++;
    end
    #1;
    check("busywait_comb", {31'd0, bus.busywait}, 32'd1);
  endtask

  task automatic finish(input bit hold, input bit perturb);
    int                hi;
    logic [DATA_W-1:0] exp;
    hi = 0;
    while (bus.busywait && hi < BOUND) begin
      check("readdata_stable", bus.readdata, last_read);
      hi++;
      @(negedge clock);
      if (perturb && hi == 2) begin
        bus.address   = 6'h01;
        bus.writedata = 32'hCAFEF00D;
      end
      #1;
    end
    check("busy_len", 32'(hi), 32'(LATENCY));
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow: got empty queue expected one entry");
    end else begin
      exp = sb.pop_front();
      check("readdata", bus.readdata, exp);
      last_read = exp;
    end
    if (!hold) begin
      bus.read  = 1'b0;
      bus.write = 1'b0;
    end
    @(negedge clock);
    #1;
    check(hold ? "rehit_busywait" : "idle_busywait", {31'd0, bus.busywait}, {31'd0, hold});
  endtask

  initial begin
    reset         = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
    do_reset();

    // read of a freshly cleared word
    start(1, 0, 6'h00, 32'h0);
    finish(0, 0);

    // write then read back the same block
    start(0, 1, 6'h2A, 32'hDEADBEEF);
    finish(0, 0);
    start(1, 0, 6'h2A, 32'h0);
    finish(0, 0);

    // inputs wiggled mid-access must be ignored
    start(0, 1, 6'h10, 32'hA5A5_0F0F);
    finish(0, 1);
    start(1, 0, 6'h10, 32'h0);
    finish(0, 0);
    start(1, 0, 6'h01, 32'h0);
    finish(0, 0);

    // read and write together: read wins, array untouched
    start(0, 1, 6'h3F, 32'h1111_2222);
    finish(0, 0);
    start(1, 1, 6'h3F, 32'h3333_4444);
    finish(0, 0);
    start(1, 0, 6'h3F, 32'h0);
    finish(0, 0);

    // reset during a write aborts it and clears the array
    start(0, 1, 6'h05, 32'h12345678);
    @(negedge clock);
    do_reset();
    start(1, 0, 6'h05, 32'h0);
    finish(0, 0);
    start(1, 0, 6'h2A, 32'h0);
    finish(0, 0);

    // random write/read pairs
    for (int i = 0; i < 6; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
      d = $urandom;
      start(0, 1, a, d);
      finish(0, 0);
      start(1, 0, a, 32'h0);
      finish(0, 0);
    end

    // read held through DONE is taken as a second request
    do_reset();
    start(1, 0, 6'h2A, 32'h0);
    finish(1, 0);
    sb.push_back(model[6'h2A]);
    n_reads++;
    finish(0, 0);

`ifdef DATA_MEM_STATS_EN
    check("read_count", {16'd0, bus.read_count}, 32'(n_reads));
    check("write_count", {16'd0, bus.write_count}, 32'(n_writes));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
